// File: rtl/alu_ctl_pkg.sv
// Shared encodings for the ALU control stage: ALUOp codes, R-type function
// codes, ALUCtl codes, FSM state type and the multi-cycle classifier.
package alu_ctl_pkg;

  // ALUOp codes from the main control unit
  localparam int OP_RTYPE = 0;
  localparam int OP_ADDI  = 1;
  localparam int OP_BEQ   = 3;
  localparam int OP_BNE   = 4;
  localparam int OP_JMP   = 5;
  localparam int OP_LW    = 6;
  localparam int OP_SLTI  = 10;
  localparam int OP_SLL   = 11;
  localparam int OP_SRL   = 12;
  localparam int OP_SW    = 13;
  localparam int OP_XOR   = 14;

  // R-type function codes (only meaningful with OP_RTYPE)
  localparam int FN_ADD = 1;
  localparam int FN_OR  = 2;
  localparam int FN_SLT = 3;
  localparam int FN_AND = 4;

  // ALUCtl codes driven towards the ALU
  localparam int CTL_ADD  = 1;
  localparam int CTL_OR   = 2;
  localparam int CTL_SLT  = 3;
  localparam int CTL_AND  = 4;
  localparam int CTL_ADDI = 5;
  localparam int CTL_BEQ  = 6;
  localparam int CTL_BNE  = 7;
  localparam int CTL_JMP  = 8;
  localparam int CTL_LW   = 9;
  localparam int CTL_SLTI = 10;
  localparam int CTL_SLL  = 11;
  localparam int CTL_SRL  = 12;
  localparam int CTL_SW   = 13;
  localparam int CTL_XOR  = 14;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MC   = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Shifts occupy the ALU for several cycles; everything else is single-cycle.
  function automatic logic is_multi_cycle(input int ctl);
    return (ctl == CTL_SLL) || (ctl == CTL_SRL);
  endfunction

endpackage

// File: rtl/alu_ctl_pipe_decode.sv
// Purely combinational ALUOp/funcCode -> ALUCtl table. Inputs are compared at
// their full width, so any set bit above the table's range makes the encoding
// illegal instead of aliasing onto a legal code.
module alu_ctl_pipe_decode #(
  parameter int OP_W        = 4,
  parameter int FUNC_W      = 3,
  parameter int CTL_W       = 4,
  parameter int ILLEGAL_CTL = 15
) (
  input  logic [OP_W-1:0]   alu_op,
  input  logic [FUNC_W-1:0] func_code,
  output logic [CTL_W-1:0]  ctl,
  output logic              illegal,
  output logic              multi
);
  import alu_ctl_pkg::*;

  int   code;
  logic legal;

  // Table lookup; legal entries yield a small integer code, zero-extended below
  always_comb begin
    code  = 0;
    legal = 1'b1;
    case (alu_op)
      OP_W'(OP_RTYPE): begin
        case (func_code)
          FUNC_W'(FN_ADD): code = CTL_ADD;
          FUNC_W'(FN_AND): code = CTL_AND;
          FUNC_W'(FN_OR):  code = CTL_OR;
          FUNC_W'(FN_SLT): code = CTL_SLT;
          default:         legal = 1'b0;
        endcase
      end
      OP_W'(OP_ADDI): code = CTL_ADDI;
      OP_W'(OP_BEQ):  code = CTL_BEQ;
      OP_W'(OP_BNE):  code = CTL_BNE;
      OP_W'(OP_JMP):  code = CTL_JMP;
      OP_W'(OP_LW):   code = CTL_LW;
      OP_W'(OP_SLTI): code = CTL_SLTI;
      OP_W'(OP_SLL):  code = CTL_SLL;
      OP_W'(OP_SRL):  code = CTL_SRL;
      OP_W'(OP_SW):   code = CTL_SW;
      OP_W'(OP_XOR):  code = CTL_XOR;
      default:        legal = 1'b0;
    endcase
  end

  // Illegal encodings force ILLEGAL_CTL and are never treated as multi-cycle
  always_comb begin
    ctl     = legal ? CTL_W'(code) : CTL_W'(ILLEGAL_CTL);
    illegal = ~legal;
    multi   = legal && is_multi_cycle(code);
  end

endmodule

// File: rtl/alu_ctl_pipe.sv
// Registered ALU control stage. Decodes ALUOp/funcCode behind a valid/ready
// handshake, holds the result until consumed, and stalls intake while a
// multi-cycle op (sll/srl) occupies the ALU for MC_CYCLES cycles.
module alu_ctl_pipe #(
  parameter int OP_W        = 4,
  parameter int FUNC_W      = 3,
  parameter int CTL_W       = 4,
  parameter int MC_CYCLES   = 4,
  parameter int ILLEGAL_CTL = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   alu_op,
  input  logic [FUNC_W-1:0] func_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTL_W-1:0]  alu_ctl,
  output logic              illegal,
  output logic              busy
);
  import alu_ctl_pkg::*;

  localparam int CNT_W = $clog2(MC_CYCLES + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CTL_W-1:0] alu_ctl_q, alu_ctl_d;
  logic             illegal_q, illegal_d;

  logic [CTL_W-1:0] dec_ctl;
  logic             dec_illegal;
  logic             dec_multi;
  logic             accept;

  alu_ctl_pipe_decode #(
    .OP_W        (OP_W),
    .FUNC_W      (FUNC_W),
    .CTL_W       (CTL_W),
    .ILLEGAL_CTL (ILLEGAL_CTL)
  ) u_decode (
    .alu_op    (alu_op),
    .func_code (func_code),
    .ctl       (dec_ctl),
    .illegal   (dec_illegal),
    .multi     (dec_multi)
  );

  // Ready depends only on state and downstream ready, never on in_valid
  always_comb begin
    in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    accept    = in_valid && in_ready;
    out_valid = (state_q == ST_HOLD);
    busy      = (state_q == ST_MC);
    alu_ctl   = alu_ctl_q;
    illegal   = illegal_q;
  end

  // Next-state, counter and result-register load logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_ctl_d = alu_ctl_q;
    illegal_d = illegal_q;

    // Result registers only change on an accept edge
    if (accept) begin
      alu_ctl_d = dec_ctl;
      illegal_d = dec_illegal;
    end

    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          // A one-cycle "multi-cycle" op needs no MC phase at all
          if (dec_multi && (MC_CYCLES > 1)) begin
            state_d = ST_MC;
            cnt_d   = CNT_W'(MC_CYCLES - 1);
          end else begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end else if ((state_q == ST_HOLD) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_MC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and result registers; reset discards any op in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      alu_ctl_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_ctl_q <= alu_ctl_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
